// File: rtl/npc_pkg.sv
// ============================================================================
// Package : npc_pkg
// Brief   : Shared constants and next-PC operation encodings for IF-stage fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package npc_pkg;

   localparam int          NPC_OP_W     = 3;
   localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NPC_EXC_VEC  = 32'h0000_4180;

   // Codes 5..7 are left undefined and behave as sequential fetch.
   typedef enum logic [NPC_OP_W-1:0] {
      NPC_PC4  = 3'd0,
      NPC_BR   = 3'd1,
      NPC_JJAL = 3'd2,
      NPC_JR   = 3'd3,
      NPC_ERET = 3'd4
   } npc_op_e;

endpackage

`default_nettype wire

// File: rtl/npc_target_calc.sv
// ============================================================================
// Module  : npc_target_calc
// Brief   : Combinational non-sequential fetch target selection (BR/J/JAL/JR/ERET).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_target_calc
   import npc_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int OP_W   = NPC_OP_W
) (
   input  logic [OP_W-1:0]   npc_op,
   input  logic [31:0]       instr_id,
   input  logic [ADDR_W-1:0] pc_id,
   input  logic [31:0]       ra,
   input  logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] target
);

   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] br_off;
   logic              unused_instr_hi;

   assign pc_plus4        = pc_id + ADDR_W'(4);
   assign br_off          = {{(ADDR_W-18){instr_id[15]}}, instr_id[15:0], 2'b00};
   assign unused_instr_hi = ^instr_id[31:26];

   // Branch and jump bases are the delay-slot address, not pc_id itself.
   always_comb begin
      target = pc_plus4;
      case (npc_op)
         NPC_BR:   target = pc_plus4 + br_off;
         NPC_JJAL: target = {pc_plus4[ADDR_W-1:28], instr_id[25:0], 2'b00};
         NPC_JR:   target = ra[ADDR_W-1:0];
         NPC_ERET: target = epc;
         default:  target = pc_plus4;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
// ============================================================================
// Module  : pc_fetch_ctrl
// Brief   : IF-stage PC owner with stall/IMEM-wait handling and held redirects.
//           Optional macro NPC_ALIGN_CHK_EN: word-align JR/ERET targets and flag
//           misalignment in a sticky status bit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_ctrl
   import npc_pkg::*;
#(
   parameter int               ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(NPC_RESET_PC),
   parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(NPC_EXC_VEC),
   parameter int               OP_W     = NPC_OP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              if_ready,
   input  logic [OP_W-1:0]   npc_op,
   input  logic              br_taken,
   input  logic [31:0]       instr_id,
   input  logic [ADDR_W-1:0] pc_id,
   input  logic [31:0]       ra,
   input  logic              exc_req,
   input  logic [ADDR_W-1:0] epc,
   output logic [ADDR_W-1:0] pc,
   output logic              redirect,
   output logic              misalign
);

   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] tgt_eff;
   logic              adv;
   logic              redir_req;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
   logic              pend_v_q, pend_v_d;
   logic              redirect_q, redirect_d;

   npc_target_calc #(
      .ADDR_W (ADDR_W),
      .OP_W   (OP_W)
   ) u_target_calc (
      .npc_op   (npc_op),
      .instr_id (instr_id),
      .pc_id    (pc_id),
      .ra       (ra),
      .epc      (epc),
      .target   (target)
   );

   assign adv       = !stall && if_ready;
   assign redir_req = !stall && ((npc_op == NPC_JJAL) || (npc_op == NPC_JR) ||
                                 (npc_op == NPC_ERET) || ((npc_op == NPC_BR) && br_taken));

`ifdef NPC_ALIGN_CHK_EN
   assign tgt_eff = {target[ADDR_W-1:2], 2'b00};
`else
   assign tgt_eff = target;
`endif

   // A redirect seen while IMEM is busy is parked and wins the next advance.
   always_comb begin
      pc_d       = pc_q;
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      redirect_d = 1'b0;
      if (exc_req) begin
         pc_d       = EXC_VEC;
         pend_v_d   = 1'b0;
         redirect_d = 1'b1;
      end else if (adv) begin
         if (pend_v_q) begin
            pc_d       = pend_tgt_q;
            pend_v_d   = 1'b0;
            redirect_d = 1'b1;
         end else if (redir_req) begin
            pc_d       = tgt_eff;
            redirect_d = 1'b1;
         end else begin
            pc_d       = pc_q + ADDR_W'(4);
         end
      end else if (redir_req) begin
         pend_tgt_d = tgt_eff;
         pend_v_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         pend_v_q   <= 1'b0;
         pend_tgt_q <= '0;
         redirect_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
         redirect_q <= redirect_d;
      end
   end

   assign pc       = pc_q;
   assign redirect = redirect_q;

`ifdef NPC_ALIGN_CHK_EN
   logic is_jr_eret;
   logic mis_now;
   logic pend_mis_q, pend_mis_d;
   logic misalign_q, misalign_d;

   assign is_jr_eret = (npc_op == NPC_JR) || (npc_op == NPC_ERET);
   assign mis_now    = is_jr_eret && (target[1:0] != 2'b00);

   // The flag is raised only when the offending target is actually loaded.
   always_comb begin
      pend_mis_d = pend_mis_q;
      misalign_d = misalign_q;
      if (exc_req) begin
         pend_mis_d = 1'b0;
      end else if (adv) begin
         if (pend_v_q) begin
            misalign_d = misalign_q | pend_mis_q;
            pend_mis_d = 1'b0;
         end else if (redir_req) begin
            misalign_d = misalign_q | mis_now;
         end
      end else if (redir_req) begin
         pend_mis_d = mis_now;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_mis_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         pend_mis_q <= pend_mis_d;
         misalign_q <= misalign_d;
      end
   end

   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

endmodule

`default_nettype wire
